// File: rtl/cordic_envelope.sv
// cordic_envelope: iterative CORDIC vectoring engine. Each accepted
// analytic-signal sample (Re, Im) is rotated onto the positive x axis and
// reported as an envelope magnitude plus the instantaneous phase
// atan2(Im, Re). One micro-rotation runs per enabled clock.
//
// Optional feature (macro CORDIC_GAIN_COMP_EN): when defined, a SCALE state
// multiplies x by 39797/65536 (~0.60725) so that Mag is the true |Re+jIm|.
// This adds one cycle of latency. When undefined, Mag carries the CORDIC
// gain (~1.6468) and the design contains no multiplier.
//
// Ports:
//   clock     in   rising-edge system clock
//   reset     in   synchronous, active-low reset (priority over EN)
//   EN        in   clock enable; all state holds while low
//   in_valid  in   Re/Im valid this cycle
//   Re, Im    in   13-bit signed real / imaginary parts
//   in_ready  out  high only in IDLE; accept = in_valid & in_ready & EN
//   out_valid out  one-cycle pulse when Mag/Phase update
//   Mag       out  15-bit unsigned magnitude, integer LSB
//   Phase     out  ZW-bit signed phase, 2^(ZW-1) LSB = pi
module cordic_envelope #(
   parameter int ITER = 12,
   parameter int ZW   = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 EN,
   input  logic                 in_valid,
   input  logic signed [12:0]   Re,
   input  logic signed [12:0]   Im,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [14:0]          Mag,
   output logic signed [ZW-1:0] Phase
);

`ifdef CORDIC_GAIN_COMP_EN
   typedef enum logic [1:0] {IDLE, ROT, SCALE, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
`endif

   localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

   state_t               state_q, state_d;
   logic [3:0]           iter_q;
   logic signed [17:0]   x_q, y_q;
   logic [ZW-1:0]        z_q;
   logic                 zero_q;

   logic signed [17:0]   re_ext, im_ext;
   logic signed [17:0]   x_sh, y_sh, x_rot, y_rot;
   logic [ZW-1:0]        z_rot;
`ifdef CORDIC_GAIN_COMP_EN
   logic signed [17:0]   x_scl;
`endif

   // atan(2^-i) in units of pi/32768
   function automatic logic [15:0] atan_lut(input logic [3:0] idx);
      case (idx)
         4'd0:    atan_lut = 16'd8192;
         4'd1:    atan_lut = 16'd4836;
         4'd2:    atan_lut = 16'd2555;
         4'd3:    atan_lut = 16'd1297;
         4'd4:    atan_lut = 16'd651;
         4'd5:    atan_lut = 16'd326;
         4'd6:    atan_lut = 16'd163;
         4'd7:    atan_lut = 16'd81;
         4'd8:    atan_lut = 16'd41;
         4'd9:    atan_lut = 16'd20;
         4'd10:   atan_lut = 16'd10;
         4'd11:   atan_lut = 16'd5;
         4'd12:   atan_lut = 16'd3;
         4'd13:   atan_lut = 16'd1;
         4'd14:   atan_lut = 16'd1;
         default: atan_lut = 16'd0;
      endcase
   endfunction

   assign in_ready = (state_q == IDLE);

   // Inputs sign-extended to 16 bits, then 2 fractional guard bits appended
   assign re_ext = {{3{Re[12]}}, Re, 2'b00};
   assign im_ext = {{3{Im[12]}}, Im, 2'b00};

   // One micro-rotation; both updates use the old x/y
   always_comb begin
      x_sh = x_q >>> iter_q;
      y_sh = y_q >>> iter_q;
      if (y_q[17]) begin
         x_rot = x_q - y_sh;
         y_rot = y_q + x_sh;
         z_rot = z_q - atan_lut(iter_q);
      end else begin
         x_rot = x_q + y_sh;
         y_rot = y_q - x_sh;
         z_rot = z_q + atan_lut(iter_q);
      end
   end

`ifdef CORDIC_GAIN_COMP_EN
   // x * 39797 >> 16, evaluated at full 35-bit product width
   assign x_scl = 18'(($signed(35'(x_q)) * 35'sd39797) >>> 16);
`endif

   always_ff @(posedge clock) begin
      if (!reset)
         state_q <= IDLE;
      else if (EN)
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = ROT;
`ifdef CORDIC_GAIN_COMP_EN
         ROT:     if (iter_q == LAST_ITER) state_d = SCALE;
         SCALE:   state_d = DONE;
`else
         ROT:     if (iter_q == LAST_ITER) state_d = DONE;
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         iter_q    <= '0;
         x_q       <= '0;
         y_q       <= '0;
         z_q       <= '0;
         zero_q    <= 1'b0;
         out_valid <= 1'b0;
         Mag       <= '0;
         Phase     <= '0;
      end else if (EN) begin
         out_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  // Left half-plane is pre-rotated by pi so CORDIC converges
                  if (Re[12]) begin
                     x_q <= -re_ext;
                     y_q <= -im_ext;
                     z_q <= {1'b1, {(ZW-1){1'b0}}};
                  end else begin
                     x_q <= re_ext;
                     y_q <= im_ext;
                     z_q <= '0;
                  end
                  zero_q <= (Re == 13'sd0) && (Im == 13'sd0);
                  iter_q <= '0;
               end
            end
            ROT: begin
               x_q    <= x_rot;
               y_q    <= y_rot;
               z_q    <= z_rot;
               iter_q <= iter_q + 4'd1;
            end
`ifdef CORDIC_GAIN_COMP_EN
            SCALE: x_q <= x_scl;
`endif
            DONE: begin
               Mag       <= x_q[16:2];
               Phase     <= zero_q ? '0 : z_q;
               out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
